// File: rtl/target_gen_multi_pkg.sv
// Shared types and constants for the multi-slot target generator.
// Holds the FSM encoding, default LFSR seeds/taps and a width helper.
package target_gen_multi_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_DRAW = 1'b1
  } state_t;

  localparam logic [7:0]  SEED_8  = 8'h55;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] SEED_16 = 16'hACE1;
  localparam logic [15:0] TAPS_16 = 16'hB400;

  // Index/range width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dffre.sv
// Generic register cell: synchronous active-high reset to RST_VAL, load when en.
module dffre #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/target_gen_multi_lfsr.sv
// Fibonacci LFSR next-state function: feedback is the parity of the tapped bits,
// shifted in at the LSB.
module lfsr_fib #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400
) (
  input  logic [W-1:0] state,
  output logic [W-1:0] next_state
);

  logic fb;

  assign fb         = ^(state & TAPS);
  assign next_state = {state[W-2:0], fb};

endmodule

// File: rtl/target_gen_multi.sv
// Multi-slot target generator: keeps NUM_TARGETS (x, y) slots filled with
// LFSR-drawn, range- and collision-checked coordinates, respawning slots on hits.
module target_gen_multi
  import target_gen_multi_pkg::*;
#(
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] TAPS        = TAPS_16,
  parameter logic [LFSR_W-1:0] SEED        = SEED_16,
  parameter int                NUM_TARGETS = 4,
  parameter int                X_W         = 5,
  parameter int                Y_W         = 5,
  parameter int                X_MAX       = 31,
  parameter int                Y_MIN       = 30,
  parameter int                Y_MAX       = 31,
  parameter int                MAX_TRIES   = 8,
  localparam int               IDX_W       = clog2_min1(NUM_TARGETS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hit_valid,
  input  logic [IDX_W-1:0]           hit_idx,
  input  logic                       seed_load,
  input  logic [LFSR_W-1:0]          seed_in,
  output logic [NUM_TARGETS-1:0]     target_valid,
  output logic [NUM_TARGETS*X_W-1:0] target_x,
  output logic [NUM_TARGETS*Y_W-1:0] target_y,
  output logic                       busy,
  output logic [LFSR_W-1:0]          lfsr_state
);

  localparam int YR_W  = clog2_min1(Y_MAX - Y_MIN + 1);
  localparam int TRY_W = clog2_min1(MAX_TRIES + 1);

  state_t                     state_reg, state_next;
  logic [LFSR_W-1:0]          lfsr_reg, lfsr_step, lfsr_next;
  logic [NUM_TARGETS-1:0]     valid_reg, valid_next;
  logic [NUM_TARGETS-1:0]     pending_reg, pending_next;
  logic [NUM_TARGETS-1:0]     sel_onehot, sel_done, hit_mask, collide_vec;
  logic [NUM_TARGETS*X_W-1:0] x_reg;
  logic [NUM_TARGETS*Y_W-1:0] y_reg;
  logic [TRY_W-1:0]           tries_reg, tries_next;
  logic [IDX_W-1:0]           slot_sel;
  logic [X_W-1:0]             raw_x, fallback_x, place_x;
  logic [YR_W-1:0]            raw_y;
  logic [Y_W-1:0]             cand_y, place_y;
  logic                       in_range, accept, fallback, complete, draw_active;

  lfsr_fib #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .state      (lfsr_reg),
    .next_state (lfsr_step)
  );

  // Candidate comes from the pre-step state so it is stable for the whole cycle.
  assign raw_x    = lfsr_reg[X_W-1:0];
  assign raw_y    = lfsr_reg[X_W +: YR_W];
  assign cand_y   = Y_W'(Y_MIN) + Y_W'(raw_y);
  assign in_range = (32'(raw_x) <= 32'(X_MAX)) && (32'(raw_y) <= 32'(Y_MAX - Y_MIN));

  generate
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_slot
      assign collide_vec[gi] = valid_reg[gi] && (x_reg[gi*X_W +: X_W] == raw_x);
      assign hit_mask[gi]    = hit_valid && (hit_idx == IDX_W'(gi));

      dffre #(.W(X_W)) u_x (
        .clk   (clk),
        .reset (reset),
        .en    (sel_done[gi]),
        .d     (place_x),
        .q     (x_reg[gi*X_W +: X_W])
      );

      dffre #(.W(Y_W)) u_y (
        .clk   (clk),
        .reset (reset),
        .en    (sel_done[gi]),
        .d     (place_y),
        .q     (y_reg[gi*Y_W +: Y_W])
      );
    end
  endgenerate

  // Lowest pending slot is always the one being drawn.
  assign sel_onehot = pending_reg & (~pending_reg + NUM_TARGETS'(1));

  always_comb begin
    slot_sel = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        slot_sel = IDX_W'(i);
      end
    end
  end

  assign fallback_x = X_W'(X_MAX - int'(slot_sel));
  assign accept     = in_range && !(|collide_vec);
  assign fallback   = !accept && (tries_reg == TRY_W'(MAX_TRIES - 1));
  assign complete   = draw_active && (accept || fallback);
  assign place_x    = accept ? raw_x : fallback_x;
  assign place_y    = accept ? cand_y : Y_W'(Y_MIN);
  assign sel_done   = complete ? sel_onehot : '0;

  // Clearing the hit bit after setting the completion bit lets a same-cycle hit win.
  assign pending_next = (pending_reg & ~sel_done) | hit_mask;
  assign valid_next   = (valid_reg | sel_done) & ~hit_mask;

  assign tries_next = complete    ? '0 :
                      draw_active ? tries_reg + TRY_W'(1) :
                                    tries_reg;

  assign lfsr_next = seed_load   ? ((seed_in == '0) ? SEED : seed_in) :
                     draw_active ? lfsr_step :
                                   lfsr_reg;

  dffre #(.W(NUM_TARGETS)) u_valid (
    .clk (clk), .reset (reset), .en (1'b1), .d (valid_next), .q (valid_reg)
  );

  dffre #(.W(NUM_TARGETS), .RST_VAL({NUM_TARGETS{1'b1}})) u_pending (
    .clk (clk), .reset (reset), .en (1'b1), .d (pending_next), .q (pending_reg)
  );

  dffre #(.W(TRY_W)) u_tries (
    .clk (clk), .reset (reset), .en (1'b1), .d (tries_next), .q (tries_reg)
  );

  dffre #(.W(LFSR_W), .RST_VAL(SEED)) u_lfsr_reg (
    .clk (clk), .reset (reset), .en (1'b1), .d (lfsr_next), .q (lfsr_reg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= STATE_DRAW;
    end else begin
      state_reg <= state_next;
    end
  end

  // Looking at pending_next lets a hit enter DRAW on the very next edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STATE_IDLE: state_next = (|pending_next) ? STATE_DRAW : STATE_IDLE;
      STATE_DRAW: state_next = (|pending_next) ? STATE_DRAW : STATE_IDLE;
      default:    state_next = STATE_DRAW;
    endcase
  end

  always_comb begin
    draw_active = (state_reg == STATE_DRAW);
    busy        = |pending_reg;
  end

  assign target_valid = valid_reg;
  assign target_x     = x_reg;
  assign target_y     = y_reg;
  assign lfsr_state   = lfsr_reg;

endmodule

// File: tb/tb_target_gen_multi.sv
// Directed bench: three generator configurations driven with hand-computed
// vectors (8-bit LFSR, taps B8, seed 55, y range 30..31).
module tb_target_gen_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DUT A: single slot
  logic       a_reset, a_hit_valid, a_seed_load, a_busy;
  logic [0:0] a_hit_idx, a_valid;
  logic [7:0] a_seed_in, a_lfsr;
  logic [4:0] a_x, a_y;

  target_gen_multi #(
    .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h55), .NUM_TARGETS(1), .X_W(5), .Y_W(5),
    .X_MAX(31), .Y_MIN(30), .Y_MAX(31), .MAX_TRIES(8)
  ) dut_a (
    .clk(clk), .reset(a_reset), .hit_valid(a_hit_valid), .hit_idx(a_hit_idx),
    .seed_load(a_seed_load), .seed_in(a_seed_in), .target_valid(a_valid),
    .target_x(a_x), .target_y(a_y), .busy(a_busy), .lfsr_state(a_lfsr)
  );

  // DUT B: four slots, collision and multi-hit
  logic        b_reset, b_hit_valid, b_seed_load, b_busy;
  logic [1:0]  b_hit_idx;
  logic [3:0]  b_valid;
  logic [7:0]  b_seed_in, b_lfsr;
  logic [19:0] b_x, b_y;

  target_gen_multi #(
    .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h55), .NUM_TARGETS(4), .X_W(5), .Y_W(5),
    .X_MAX(31), .Y_MIN(30), .Y_MAX(31), .MAX_TRIES(8)
  ) dut_b (
    .clk(clk), .reset(b_reset), .hit_valid(b_hit_valid), .hit_idx(b_hit_idx),
    .seed_load(b_seed_load), .seed_in(b_seed_in), .target_valid(b_valid),
    .target_x(b_x), .target_y(b_y), .busy(b_busy), .lfsr_state(b_lfsr)
  );

  // DUT C: two slots, X_MAX=0 forces the fallback path
  logic       c_reset, c_hit_valid, c_seed_load, c_busy;
  logic [0:0] c_hit_idx;
  logic [1:0] c_valid;
  logic [7:0] c_seed_in, c_lfsr;
  logic [9:0] c_x, c_y;

  target_gen_multi #(
    .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h55), .NUM_TARGETS(2), .X_W(5), .Y_W(5),
    .X_MAX(0), .Y_MIN(30), .Y_MAX(31), .MAX_TRIES(4)
  ) dut_c (
    .clk(clk), .reset(c_reset), .hit_valid(c_hit_valid), .hit_idx(c_hit_idx),
    .seed_load(c_seed_load), .seed_in(c_seed_in), .target_valid(c_valid),
    .target_x(c_x), .target_y(c_y), .busy(c_busy), .lfsr_state(c_lfsr)
  );

  initial begin
    a_reset = 1; a_hit_valid = 0; a_hit_idx = 0; a_seed_load = 0; a_seed_in = 0;
    b_reset = 1; b_hit_valid = 0; b_hit_idx = 0; b_seed_load = 0; b_seed_in = 0;
    c_reset = 1; c_hit_valid = 0; c_hit_idx = 0; c_seed_load = 0; c_seed_in = 0;
    step();
    step();

    // Reset state
    check("a_rst_valid", 32'(a_valid), 0);
    check("a_rst_x", 32'(a_x), 0);
    check("a_rst_busy", 32'(a_busy), 1);
    check("a_rst_lfsr", 32'(a_lfsr), 32'h55);

    // Test 1: first spawn
    a_reset = 0;
    step();
    check("t1_valid", 32'(a_valid), 1);
    check("t1_x", 32'(a_x), 21);
    check("t1_y", 32'(a_y), 30);
    check("t1_lfsr", 32'(a_lfsr), 32'hAB);
    check("t1_busy", 32'(a_busy), 0);

    // Out-of-range hit index is ignored
    a_hit_idx = 1; a_hit_valid = 1;
    step();
    a_hit_valid = 0;
    check("oor_valid", 32'(a_valid), 1);
    check("oor_busy", 32'(a_busy), 0);
    check("oor_lfsr", 32'(a_lfsr), 32'hAB);

    // Test 2: hit and respawn at t+2
    a_hit_idx = 0; a_hit_valid = 1;
    step();
    a_hit_valid = 0;
    check("t2_hit_valid", 32'(a_valid), 0);
    check("t2_hit_busy", 32'(a_busy), 1);
    check("t2_hold_x", 32'(a_x), 21);
    step();
    check("t2_valid", 32'(a_valid), 1);
    check("t2_x", 32'(a_x), 11);
    check("t2_y", 32'(a_y), 31);
    check("t2_lfsr", 32'(a_lfsr), 32'h57);
    check("t2_busy", 32'(a_busy), 0);

    // Test 6: reset during DRAW restarts from SEED
    a_hit_valid = 1;
    step();
    a_hit_valid = 0;
    a_reset = 1;
    step();
    a_reset = 0;
    check("t6_rst_valid", 32'(a_valid), 0);
    check("t6_rst_x", 32'(a_x), 0);
    check("t6_rst_y", 32'(a_y), 0);
    check("t6_rst_lfsr", 32'(a_lfsr), 32'h55);
    step();
    check("t6_valid", 32'(a_valid), 1);
    check("t6_x", 32'(a_x), 21);
    check("t6_y", 32'(a_y), 30);
    check("t6_lfsr", 32'(a_lfsr), 32'hAB);
    check("t6_busy", 32'(a_busy), 0);

    // Hit in the cycle the slot completes: hit wins, another draw follows
    a_hit_valid = 1;
    step();
    step();
    a_hit_valid = 0;
    check("hw_valid", 32'(a_valid), 0);
    check("hw_busy", 32'(a_busy), 1);
    check("hw_lfsr", 32'(a_lfsr), 32'h57);
    step();
    check("hw_re_valid", 32'(a_valid), 1);
    check("hw_re_x", 32'(a_x), 23);
    check("hw_re_y", 32'(a_y), 30);
    check("hw_re_lfsr", 32'(a_lfsr), 32'hAF);

    // DUT B: initial fill of four slots, one per cycle
    b_reset = 0;
    step(); check("b_fill1", 32'(b_valid), 4'h1);
    step(); check("b_fill2", 32'(b_valid), 4'h3);
    step(); check("b_fill3", 32'(b_valid), 4'h7);
    step(); check("b_fill4", 32'(b_valid), 4'hF);
    check("b_fill_x0", 32'(b_x[0 +: 5]), 21);
    check("b_fill_x1", 32'(b_x[5 +: 5]), 11);
    check("b_fill_x2", 32'(b_x[10 +: 5]), 23);
    check("b_fill_x3", 32'(b_x[15 +: 5]), 15);
    check("b_fill_y3", 32'(b_y[15 +: 5]), 31);
    check("b_fill_lfsr", 32'(b_lfsr), 32'h5F);
    check("b_fill_busy", 32'(b_busy), 0);

    // Test 3: reseed so the first candidate (x=21) collides with slot 0
    b_hit_idx = 1; b_hit_valid = 1; b_seed_load = 1; b_seed_in = 8'h55;
    step();
    b_hit_valid = 0; b_seed_load = 0;
    check("t3_valid", 32'(b_valid), 4'hD);
    check("t3_lfsr", 32'(b_lfsr), 32'h55);
    step();
    check("t3_rej_valid", 32'(b_valid), 4'hD);
    check("t3_rej_busy", 32'(b_busy), 1);
    check("t3_rej_lfsr", 32'(b_lfsr), 32'hAB);
    step();
    check("t3_acc_valid", 32'(b_valid), 4'hF);
    check("t3_acc_x1", 32'(b_x[5 +: 5]), 11);
    check("t3_acc_y1", 32'(b_y[5 +: 5]), 31);
    check("t3_acc_lfsr", 32'(b_lfsr), 32'h57);
    check("t3_acc_busy", 32'(b_busy), 0);

    // Test 5: zero seed substitutes SEED, then hits on slots 0 and 2
    b_seed_load = 1; b_seed_in = 8'h00;
    step();
    b_seed_load = 0;
    check("t5_seed_lfsr", 32'(b_lfsr), 32'h55);
    check("t5_seed_busy", 32'(b_busy), 0);
    b_hit_idx = 0; b_hit_valid = 1;
    step();
    b_hit_idx = 2;
    check("t5_h0_valid", 32'(b_valid), 4'hE);
    step();
    b_hit_valid = 0;
    check("t5_s0_valid", 32'(b_valid), 4'hB);
    check("t5_s0_x0", 32'(b_x[0 +: 5]), 21);
    check("t5_s0_y0", 32'(b_y[0 +: 5]), 30);
    check("t5_s0_busy", 32'(b_busy), 1);
    step();
    check("t5_rej_valid", 32'(b_valid), 4'hB);
    check("t5_rej_busy", 32'(b_busy), 1);
    check("t5_rej_lfsr", 32'(b_lfsr), 32'h57);
    step();
    check("t5_s2_valid", 32'(b_valid), 4'hF);
    check("t5_s2_x2", 32'(b_x[10 +: 5]), 23);
    check("t5_s2_y2", 32'(b_y[10 +: 5]), 30);
    check("t5_s2_lfsr", 32'(b_lfsr), 32'hAF);
    check("t5_s2_busy", 32'(b_busy), 0);

    // DUT C: every draw is out of range, so both slots use the fallback
    c_reset = 0;
    step(); step(); step();
    check("c_s0_wait_valid", 32'(c_valid), 0);
    step();
    check("c_s0_valid", 32'(c_valid), 2'b01);
    check("c_s0_x", 32'(c_x[0 +: 5]), 0);
    check("c_s0_y", 32'(c_y[0 +: 5]), 30);
    check("c_s0_lfsr", 32'(c_lfsr), 32'h5F);
    step(); step(); step(); step();
    check("c_s1_valid", 32'(c_valid), 2'b11);
    check("c_s1_x", 32'(c_x[5 +: 5]), 31);
    check("c_s1_lfsr", 32'(c_lfsr), 32'hF2);
    check("c_s1_busy", 32'(c_busy), 0);

    // Test 4: hit slot 1 twice (second hit idempotent), fallback after 4 draws
    c_hit_idx = 1; c_hit_valid = 1;
    step();
    check("t4_hit_valid", 32'(c_valid), 2'b01);
    check("t4_hit_lfsr", 32'(c_lfsr), 32'hF2);
    step();
    c_hit_valid = 0;
    check("t4_d1_lfsr", 32'(c_lfsr), 32'hE5);
    step();
    check("t4_d2_lfsr", 32'(c_lfsr), 32'hCA);
    step();
    check("t4_d3_valid", 32'(c_valid), 2'b01);
    check("t4_d3_busy", 32'(c_busy), 1);
    step();
    check("t4_fb_valid", 32'(c_valid), 2'b11);
    check("t4_fb_x", 32'(c_x[5 +: 5]), 31);
    check("t4_fb_y", 32'(c_y[5 +: 5]), 30);
    check("t4_fb_lfsr", 32'(c_lfsr), 32'h28);
    check("t4_fb_busy", 32'(c_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/target_gen_multi.md
Name: target_gen_multi

Overview:
Parametrised successor to the single-target generator. Maintains NUM_TARGETS independent target slots, each with an (x, y) coordinate drawn from a configurable Fibonacci LFSR. Draws are range-checked and collision-checked by rejection sampling. A hit on a slot clears it and queues a respawn. Sits between the hit/scoring logic (which raises hit_valid) and the display/collision logic (which reads target_x/target_y).

Parameters:
LFSR_W, 16, LFSR state width (≥ X_W + YR_W, where YR_W = max(1, clog2(Y_MAX-Y_MIN+1)))
TAPS, 16'hB400, feedback tap mask; bit i set means state[i] is XORed into feedback
SEED, 16'hACE1, reset/default seed; must be nonzero
NUM_TARGETS, 4, number of target slots (1..8)
X_W, 5, x coordinate width
Y_W, 5, y coordinate width
X_MAX, 31, largest legal x
Y_MIN, 30, smallest legal y
Y_MAX, 31, largest legal y
MAX_TRIES, 8, rejected draws allowed before the fallback placement

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hit_valid  in  1  one-cycle pulse: slot hit_idx was hit
hit_idx  in  clog2(NUM_TARGETS) (min 1)  slot index for hit_valid
seed_load  in  1  load seed_in into the LFSR this cycle
seed_in  in  LFSR_W  new seed; zero substitutes SEED
target_valid  out  NUM_TARGETS  slot i holds a live target
target_x  out  NUM_TARGETS*X_W  packed x, slot i at [i*X_W +: X_W]
target_y  out  NUM_TARGETS*Y_W  packed y, slot i at [i*Y_W +: Y_W]
busy  out  1  a respawn is pending or in progress
lfsr_state  out  LFSR_W  current LFSR state (debug/verification)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
- Reset values: lfsr=SEED; target_valid=0; all target_x/target_y=0; try counter=0; pending mask=all ones (every slot queued to spawn); FSM=DRAW.
- LFSR step: fb = ^(lfsr & TAPS); next = {lfsr[LFSR_W-2:0], fb}.
- The LFSR steps only in DRAW cycles, never idles forward, and never holds zero.
- Candidate, taken from the current (pre-step) lfsr:
  - raw_x = lfsr[X_W-1:0]; raw_y = lfsr[X_W +: YR_W]; cand_y = Y_MIN + raw_y.
  - Accept iff raw_x ≤ X_MAX, raw_y ≤ Y_MAX-Y_MIN, and no valid slot has x == raw_x.
- FSM states:
  - IDLE: pending==0, busy=0. Any pending bit set moves to DRAW next cycle.
  - DRAW: target slot s = lowest-index pending bit. Every cycle the LFSR steps.
    - On accept: slot s gets {raw_x, cand_y}; target_valid[s]<=1; pending[s]<=0; tries<=0.
    - On reject: tries++.
    - If tries == MAX_TRIES-1 and the candidate is rejected: fallback places x = X_MAX - s, y = Y_MIN, ignoring collision, and completes the slot as on accept.
    - After a completed slot, go to IDLE if no other pending bit is set, else stay in DRAW.
  - busy = (pending != 0).
- Hit handling:
  - hit_valid at edge t: target_valid[hit_idx]<=0 and pending[hit_idx]<=1, visible at t+1.
  - Best-case respawn is visible at t+2.
  - hit_idx ≥ NUM_TARGETS is ignored.
  - A hit on an invalid or already-pending slot is idempotent (no extra draw).
- Simultaneous events:
  - hit on slot s in the same cycle slot s completes a draw: the hit wins (valid=0, pending=1).
  - seed_load in a DRAW cycle: the loaded value replaces the step; the candidate from the old state is still evaluated and applied.
  - reset overrides everything.
- Reset mid-draw: all slots cleared and the full respawn sequence restarts from SEED.
- Coordinate outputs hold their last value while invalid; consumers must qualify them with target_valid.
- Worst-case respawn latency per slot: MAX_TRIES cycles.

Decomposition:
- Shared package: STATE_IDLE/STATE_DRAW encoding and the default SEED/TAPS constants per LFSR width (8'h55/8'hB8 and 16'hACE1/16'hB400).
- Sub-module lfsr_fib #(W, TAPS), combinational next-state.
- Slot registers, pending mask, tries counter and LFSR state use the existing dffre register cell.

Test Plan:
1. Reset out (LFSR_W=8, TAPS=8'hB8, SEED=8'h55, NUM_TARGETS=1, Y 30..31) -> one cycle after reset falls, target_valid=1, x=21, y=30, lfsr_state=8'hAB, busy=0.
2. Same config, hit_valid with hit_idx=0 -> next cycle valid=0 and busy=1; following cycle x=11, y=31, lfsr_state=8'h57.
3. Collision: NUM_TARGETS=2, force a seed whose first candidate equals slot 0's x -> draw rejected, tries=1, slot 1 x differs from slot 0 x.
4. Fallback: X_MAX=0, MAX_TRIES=4, hit slot 1 -> after 4 DRAW cycles slot 1 has x = X_MAX-1 (wraps mod 2^X_W, i.e. 31), y = Y_MIN, valid=1.
5. seed_load with seed_in=0 -> lfsr_state=SEED next cycle. Hits on slots 0 and 2 in consecutive cycles -> both respawn, slot 0 first, busy low only after both complete.
6. reset asserted mid-DRAW -> next cycle all valid=0, coordinates=0, lfsr_state=SEED; the test-1 sequence then repeats exactly.
